owl_frmbuf: RTL and testbench

OWL_FRMBUF -- requirements
Module: owl_frmbuf

---
 rtl/owl_frmbuf_pkg.sv | 15 +
 rtl/owl_fifo.sv | 47 ++++
 rtl/owl_frmbuf.sv | 122 ++++++++++++
 tb/tb_owl_frmbuf.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/owl_frmbuf_pkg.sv
// Shared definitions for the OWL frame buffer: TX sequencer state encoding
// and the default FIFO depth exponent.
package owl_frmbuf_pkg;

  localparam int OWL_AW_DEF = 4;

  typedef enum logic [2:0] {
    T_IDLE  = 3'd0,
    T_LOAD  = 3'd1,
    T_WSET  = 3'd2,
    T_WCLR  = 3'd3,
    T_DRAIN = 3'd4
  } tx_state_e;

endpackage

// File: rtl/owl_fifo.sv
// Byte FIFO, 2^AW deep, first-word-fall-through, wrap-bit pointers.
// A pop in the same cycle frees a slot, so push+pop succeed even when full.
module owl_fifo
  import owl_frmbuf_pkg::*;
#(
  parameter int AW = OWL_AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr,
  input  logic [7:0]    wdata,
  input  logic          rd,
  output logic [7:0]    rdata,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  localparam int          DEPTH   = 1 << AW;
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wptr, rptr;
  logic        do_wr, do_rd;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign count = wptr - rptr;
  assign do_rd = rd && !empty;
  assign do_wr = wr && (!full || do_rd);
  assign rdata = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_wr) wptr <= wptr + PTR_ONE;
      if (do_rd) rptr <= rptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/owl_frmbuf.sv
// Frame buffer between a host and an OWL line transceiver: a TX FIFO drained
// byte-by-byte into the transceiver, and an RX FIFO filled from it.
module owl_frmbuf
  import owl_frmbuf_pkg::*;
#(
  parameter int AW = OWL_AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tx_wr,
  input  logic [7:0]    tx_wdata,
  input  logic          tx_go,
  output logic          tx_full,
  output logic          tx_busy,
  output logic          tx_done,
  input  logic          rx_rd,
  output logic [7:0]    rx_rdata,
  output logic          rx_empty,
  output logic [AW:0]   rx_len,
  output logic          rx_done,
  output logic          rx_ovf,
  input  logic          rx_clr,
  output logic          owl_wctrl,
  output logic [7:0]    owl_wdata,
  input  logic          owl_wflag,
  input  logic          owl_oe,
  output logic          owl_rctrl,
  input  logic [7:0]    owl_rdata,
  input  logic          owl_rflag,
  input  logic          owl_rxsof,
  input  logic          owl_rxeof,
  output tx_state_e     tx_state,
  output logic [AW:0]   tx_level,
  output logic [AW:0]   rx_level
);

  localparam logic [AW:0] CNT_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0] CNT_MAX = '1;

  tx_state_e   state_q, state_d;
  logic [7:0]  tx_head;
  logic        tx_empty, tx_pop;
  logic        rx_full, rx_pop, rx_drop;
  logic        oe_q, oe_fall, rflag_q, rflag_rise;
  logic [AW:0] rx_cnt;

  assign oe_fall    = oe_q & ~owl_oe;
  assign rflag_rise = owl_rflag & ~rflag_q;
  assign rx_pop     = rx_rd & ~rx_empty;
  assign rx_drop    = rflag_rise & rx_full & ~rx_pop;
  assign tx_state   = state_q;

  owl_fifo #(.AW(AW)) u_tx_fifo (
    .clk(clk), .rst(rst), .wr(tx_wr), .wdata(tx_wdata), .rd(tx_pop),
    .rdata(tx_head), .full(tx_full), .empty(tx_empty), .count(tx_level)
  );

  owl_fifo #(.AW(AW)) u_rx_fifo (
    .clk(clk), .rst(rst), .wr(rflag_rise), .wdata(owl_rdata), .rd(rx_rd),
    .rdata(rx_rdata), .full(rx_full), .empty(rx_empty), .count(rx_level)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= T_IDLE;
    else      state_q <= state_d;
  end

  // Transceiver handshake: a one-cycle owl_wctrl offers owl_wdata; the
  // transceiver answers with owl_wflag high for the byte time, and its fall
  // means it can take the next byte, which is offered on the following cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      T_IDLE:  if (tx_go && !tx_empty) state_d = T_LOAD;
      T_LOAD:  state_d = T_WSET;
      T_WSET:  if (owl_wflag) state_d = T_WCLR;
      T_WCLR:  if (!owl_wflag) state_d = tx_empty ? T_DRAIN : T_LOAD;
      T_DRAIN: if (oe_fall) state_d = T_IDLE;
      default: state_d = T_IDLE;
    endcase
  end

  always_comb begin
    owl_wctrl = 1'b0;
    owl_wdata = '0;
    tx_pop    = 1'b0;
    tx_busy   = (state_q != T_IDLE);
    if (state_q == T_LOAD) begin
      owl_wctrl = 1'b1;
      owl_wdata = tx_head;
      tx_pop    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      oe_q      <= 1'b0;
      rflag_q   <= 1'b0;
      owl_rctrl <= 1'b0;
      tx_done   <= 1'b0;
      rx_done   <= 1'b0;
      rx_cnt    <= '0;
      rx_len    <= '0;
      rx_ovf    <= 1'b0;
    end else begin
      oe_q      <= owl_oe;
      rflag_q   <= owl_rflag;
      owl_rctrl <= rflag_rise;
      tx_done   <= (state_q == T_DRAIN) && oe_fall;
      rx_done   <= owl_rxeof;
      if (owl_rxeof) rx_len <= rx_cnt;
      // Start-of-frame clear wins over the old count; a same-cycle byte still counts.
      if (owl_rxsof)
        rx_cnt <= rflag_rise ? CNT_ONE : '0;
      else if (rflag_rise && rx_cnt != CNT_MAX)
        rx_cnt <= rx_cnt + CNT_ONE;
      if (rx_drop)     rx_ovf <= 1'b1;
      else if (rx_clr) rx_ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_owl_frmbuf.sv
// Bench for owl_frmbuf: transceiver model on both sides, queue-based reference
// for frame contents, byte counts and overflow.
module tb_owl_frmbuf;
  import owl_frmbuf_pkg::*;

  localparam int AW      = 4;
  localparam int DEPTH   = 1 << AW;
  localparam int CNT_SAT = (1 << (AW + 1)) - 1;

  logic          clk, rst;
  logic          tx_wr, tx_go, tx_full, tx_busy, tx_done;
  logic [7:0]    tx_wdata;
  logic          rx_rd, rx_empty, rx_done, rx_ovf, rx_clr;
  logic [7:0]    rx_rdata;
  logic [AW:0]   rx_len, tx_level, rx_level;
  logic          owl_wctrl, owl_wflag, owl_oe, owl_rctrl;
  logic          owl_rflag, owl_rxsof, owl_rxeof;
  logic [7:0]    owl_wdata, owl_rdata;
  tx_state_e     tx_state;

  int n_checks = 0, n_fail = 0;
  int cyc = 0;
  int wctrl_hi = 0, rctrl_hi = 0, busy_hi = 0, done_cnt = 0, rx_done_cnt = 0;
  int done_cyc = -1, oe_fall_cyc = -1, late_cnt = 0;
  int wflag_hold = 80;

  logic [7:0] exp_q[$];
  logic [7:0] obs_q[$];
  logic [7:0] rx_exp_q[$];
  int         mdl_cnt = 0;
  bit         mdl_ovf = 1'b0;

  owl_frmbuf #(.AW(AW)) dut (
    .clk(clk), .rst(rst),
    .tx_wr(tx_wr), .tx_wdata(tx_wdata), .tx_go(tx_go),
    .tx_full(tx_full), .tx_busy(tx_busy), .tx_done(tx_done),
    .rx_rd(rx_rd), .rx_rdata(rx_rdata), .rx_empty(rx_empty), .rx_len(rx_len),
    .rx_done(rx_done), .rx_ovf(rx_ovf), .rx_clr(rx_clr),
    .owl_wctrl(owl_wctrl), .owl_wdata(owl_wdata), .owl_wflag(owl_wflag),
    .owl_oe(owl_oe), .owl_rctrl(owl_rctrl), .owl_rdata(owl_rdata),
    .owl_rflag(owl_rflag), .owl_rxsof(owl_rxsof), .owl_rxeof(owl_rxeof),
    .tx_state(tx_state), .tx_level(tx_level), .rx_level(rx_level)
  );

  // clock / cycle count
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cyc <= cyc + 1;

  // pulse monitor
  always @(negedge clk) begin
    if (owl_wctrl === 1'b1) wctrl_hi++;
    if (owl_rctrl === 1'b1) rctrl_hi++;
    if (tx_busy === 1'b1)   busy_hi++;
    if (rx_done === 1'b1)   rx_done_cnt++;
    if (tx_done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  // transceiver write-side model
  initial begin : xcvr
    bit more;
    owl_wflag = 1'b0;
    owl_oe    = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (owl_wctrl === 1'b1) begin
        owl_oe = 1'b1;
        more   = 1'b1;
        while (more) begin
          obs_q.push_back(owl_wdata);
          @(posedge clk); #1 owl_wflag = 1'b1;
          repeat (wflag_hold) @(posedge clk);
          #1 owl_wflag = 1'b0;
          @(posedge clk); #1;
          more = (owl_wctrl === 1'b1);
        end
        for (int i = 0; i < 4; i++) begin
          @(posedge clk); #1;
          if (owl_wctrl === 1'b1) late_cnt++;
        end
        repeat ($urandom_range(2, 8)) @(posedge clk);
        #1 owl_oe = 1'b0;
        oe_fall_cyc = cyc;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // driver tasks: all start and end just after a falling edge
  task automatic tx_push(input logic [7:0] d);
    tx_wr = 1'b1; tx_wdata = d;
    @(negedge clk);
    tx_wr = 1'b0;
    if (exp_q.size() < DEPTH) exp_q.push_back(d);
  endtask

  task automatic run_tx(input string tag, input int hold, input bit mid_push);
    logic [7:0] want[$];
    logic [7:0] d;
    int d0, w0, l0, n, budget;
    wflag_hold = hold;
    want = exp_q;
    exp_q.delete();
    obs_q.delete();
    d0 = done_cnt; w0 = wctrl_hi; l0 = late_cnt;
    tx_go = 1'b1;
    @(negedge clk);
    tx_go = 1'b0;
    if (mid_push) begin
      n = 0;
      while (tx_state != T_WCLR && n < 500) begin @(negedge clk); n++; end
      check_eq({tag, "_wclr_seen"}, 32'(tx_state == T_WCLR), 1);
      d = 8'($urandom_range(0, 255));
      tx_wr = 1'b1; tx_wdata = d;
      @(negedge clk);
      tx_wr = 1'b0;
      want.push_back(d);
    end
    budget = 300 + want.size() * (hold + 20);
    n = 0;
    while (done_cnt == d0 && n < budget) begin @(negedge clk); n++; end
    repeat (4) @(negedge clk);
    check_eq({tag, "_done_seen"}, 32'(done_cnt != d0), 1);
    check_eq({tag, "_nbytes"}, 32'(obs_q.size()), 32'(want.size()));
    for (int i = 0; i < want.size(); i++)
      check_eq($sformatf("%s_byte%0d", tag, i),
               (i < obs_q.size()) ? 32'(obs_q[i]) : 32'hFFFF_FFFF, 32'(want[i]));
    check_eq({tag, "_wctrl_cycles"}, 32'(wctrl_hi - w0), 32'(want.size()));
    check_eq({tag, "_done_pulses"}, 32'(done_cnt - d0), 1);
    check_eq({tag, "_done_after_oe"}, 32'(done_cyc), 32'(oe_fall_cyc + 1));
    check_eq({tag, "_late_wctrl"}, 32'(late_cnt - l0), 0);
    check_eq({tag, "_busy_end"}, 32'(tx_busy), 0);
  endtask

  task automatic rx_frame(input string tag, input int n, input bit sof_same,
                          input bit rnd, input int base);
    logic [7:0] d;
    int r0, x0;
    r0 = rctrl_hi; x0 = rx_done_cnt;
    if (!sof_same) begin
      owl_rxsof = 1'b1;
      @(negedge clk);
      owl_rxsof = 1'b0;
    end
    mdl_cnt = 0;
    for (int i = 0; i < n; i++) begin
      d = rnd ? 8'($urandom_range(0, 255)) : 8'(base + i);
      owl_rdata = d; owl_rflag = 1'b1;
      if (sof_same && i == 0) owl_rxsof = 1'b1;
      @(negedge clk);
      owl_rflag = 1'b0; owl_rxsof = 1'b0;
      repeat ($urandom_range(1, 3)) @(negedge clk);
      mdl_cnt = (mdl_cnt < CNT_SAT) ? mdl_cnt + 1 : CNT_SAT;
      if (rx_exp_q.size() < DEPTH) rx_exp_q.push_back(d);
      else mdl_ovf = 1'b1;
    end
    owl_rxeof = 1'b1;
    @(negedge clk);
    owl_rxeof = 1'b0;
    check_eq({tag, "_rx_done"}, 32'(rx_done), 1);
    check_eq({tag, "_rx_len"}, 32'(rx_len), 32'(mdl_cnt));
    repeat (2) @(negedge clk);
    check_eq({tag, "_rx_done_pulses"}, 32'(rx_done_cnt - x0), 1);
    check_eq({tag, "_rctrl_cycles"}, 32'(rctrl_hi - r0), 32'(n));
    check_eq({tag, "_rx_ovf"}, 32'(rx_ovf), 32'(mdl_ovf));
  endtask

  task automatic rx_drain(input string tag);
    int i = 0;
    while (rx_exp_q.size() > 0) begin
      check_eq($sformatf("%s_empty%0d", tag, i), 32'(rx_empty), 0);
      check_eq($sformatf("%s_pop%0d", tag, i), 32'(rx_rdata), 32'(rx_exp_q.pop_front()));
      rx_rd = 1'b1;
      @(negedge clk);
      rx_rd = 1'b0;
      i++;
    end
    check_eq({tag, "_empty_end"}, 32'(rx_empty), 1);
  endtask

  initial begin : main
    int b0, w0, d0, x0, n;
    rst = 1'b0;
    tx_wr = 1'b0; tx_wdata = '0; tx_go = 1'b0;
    rx_rd = 1'b0; rx_clr = 1'b0;
    owl_rdata = '0; owl_rflag = 1'b0; owl_rxsof = 1'b0; owl_rxeof = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_tx_busy", 32'(tx_busy), 0);
    check_eq("rst_tx_full", 32'(tx_full), 0);
    check_eq("rst_tx_done", 32'(tx_done), 0);
    check_eq("rst_rx_empty", 32'(rx_empty), 1);
    check_eq("rst_rx_len", 32'(rx_len), 0);
    check_eq("rst_rx_ovf", 32'(rx_ovf), 0);
    check_eq("rst_rx_done", 32'(rx_done), 0);
    check_eq("rst_wctrl", 32'(owl_wctrl), 0);
    check_eq("rst_wdata", 32'(owl_wdata), 0);
    check_eq("rst_rctrl", 32'(owl_rctrl), 0);
    check_eq("rst_state", 32'(tx_state), 32'(T_IDLE));
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // three-byte frame with an 80-cycle byte time
    tx_push(8'hA5); tx_push(8'h3C); tx_push(8'h81);
    run_tx("frame3", 80, 1'b0);

    // tx_go with nothing buffered
    b0 = busy_hi; w0 = wctrl_hi;
    tx_go = 1'b1;
    @(negedge clk);
    tx_go = 1'b0;
    repeat (20) @(negedge clk);
    check_eq("go_empty_busy", 32'(busy_hi - b0), 0);
    check_eq("go_empty_wctrl", 32'(wctrl_hi - w0), 0);

    // fill to full, drop the 17th, extend the frame mid-flight
    for (int i = 0; i < DEPTH; i++) tx_push(8'($urandom_range(0, 255)));
    check_eq("fill_full", 32'(tx_full), 1);
    tx_push(8'($urandom_range(0, 255)));
    check_eq("fill_full_after_drop", 32'(tx_full), 1);
    check_eq("fill_level", 32'(tx_level), 32'(DEPTH));
    run_tx("frame17", $urandom_range(3, 10), 1'b1);
    check_eq("frame17_not_full", 32'(tx_full), 0);

    // random frames
    for (int f = 0; f < 4; f++) begin
      n = $urandom_range(1, DEPTH);
      for (int i = 0; i < n; i++) tx_push(8'($urandom_range(0, 255)));
      run_tx($sformatf("rnd%0d", f), $urandom_range(1, 12), 1'b0);
    end

    // RX: five bytes 11..15
    rx_frame("rx5", 5, 1'b0, 1'b0, 11);
    rx_drain("rx5");

    // RX: start-of-frame coinciding with the first byte
    rx_frame("rxsof", 7, 1'b1, 1'b1, 0);
    rx_drain("rxsof");

    // RX overflow: 17 bytes, no reads
    rx_frame("rx17", 17, 1'b0, 1'b1, 0);
    rx_drain("rx17");
    rx_clr = 1'b1;
    @(negedge clk);
    rx_clr = 1'b0;
    mdl_ovf = 1'b0;
    check_eq("rx_clr_ovf", 32'(rx_ovf), 0);

    // RX counter saturation, FIFO left full
    rx_frame("rxsat", 35, 1'b1, 1'b1, 0);

    // reset while waiting for the transceiver's wflag
    tx_push(8'h5A); tx_push(8'hC3); tx_push(8'h0F);
    wflag_hold = 40;
    tx_go = 1'b1;
    @(negedge clk);
    tx_go = 1'b0;
    n = 0;
    while (tx_state != T_WSET && n < 50) begin @(negedge clk); n++; end
    check_eq("mid_rst_wset_seen", 32'(tx_state == T_WSET), 1);
    d0 = done_cnt; x0 = rx_done_cnt;
    rst = 1'b0;
    #1;
    check_eq("mid_rst_state", 32'(tx_state), 32'(T_IDLE));
    check_eq("mid_rst_busy", 32'(tx_busy), 0);
    check_eq("mid_rst_wctrl", 32'(owl_wctrl), 0);
    check_eq("mid_rst_wdata", 32'(owl_wdata), 0);
    check_eq("mid_rst_tx_full", 32'(tx_full), 0);
    check_eq("mid_rst_rx_empty", 32'(rx_empty), 1);
    check_eq("mid_rst_rx_len", 32'(rx_len), 0);
    check_eq("mid_rst_rx_ovf", 32'(rx_ovf), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    rx_exp_q.delete();
    mdl_ovf = 1'b0;
    repeat (150) @(negedge clk);
    check_eq("post_rst_no_tx_done", 32'(done_cnt - d0), 0);
    check_eq("post_rst_no_rx_done", 32'(rx_done_cnt - x0), 0);
    check_eq("post_rst_busy", 32'(tx_busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
